// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the write-back arbiter.
// The entry struct carries the widest data path; narrower builds zero the upper half.
package wb_arbiter_pkg;

  localparam int WB_DAT_MAX_W = 64;
  localparam int WB_RD_W      = 5;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;

  typedef struct packed {
    logic                    vld;
    logic [WB_RD_W-1:0]      rd;
    logic [WB_DAT_MAX_W-1:0] dat;
  } wb_entry_t;

  // True when two or more bits of the (zero-extended) vector are set.
  function automatic logic multi_hot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/wb_rr_arb.sv
// Round-robin grant: lowest requesting index at or after ptr (wrapping) wins.
// Purely combinational; en=0 forces an all-zero grant.
module wb_rr_arb #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin selects one requester into a single output
// register that feeds the register file and the bypass network.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int RV64       = 0,
  parameter  int NUM_REQ    = 3,
  parameter  int CNT_WIDTH  = 16,
  localparam int DATA_WIDTH = 32 * (1 + RV64)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    iReqVld,
  input  logic [NUM_REQ-1:0][WB_RD_W-1:0]       iReqRd,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    iReqDat,
  output logic [NUM_REQ-1:0]                    oReqRdy,
  input  logic                                  iWbRdy,
  output wb_entry_t                             oWbBus,
  output wb_entry_t                             oFwdBus,
  output logic [CNT_WIDTH-1:0]                  oConflictCnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic                 stage_free;
  logic                 transfer;
  logic [NUM_REQ-1:0]   gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     ptr_d, ptr_q;
  wb_entry_t            out_d, out_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  wb_entry_t            bus;

  assign stage_free = !out_q.vld || iWbRdy;

  // Gating with rst keeps oReqRdy low for as long as reset is held.
  wb_rr_arb #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arb (
    .req    (iReqVld),
    .ptr    (ptr_q),
    .en     (stage_free && rst),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign transfer = |gnt;
  assign oReqRdy  = gnt;

  always_comb begin
    out_d = out_q;
    if (transfer) begin
      out_d.vld = 1'b1;
      out_d.rd  = iReqRd[gnt_idx];
      out_d.dat = WB_DAT_MAX_W'(iReqDat[gnt_idx]);
    end else if (iWbRdy) begin
      out_d.vld = 1'b0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (multi_hot(8'(iReqVld)) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // A consumed rd=0 entry still occupies the stage but is never visible.
  always_comb begin
    bus     = out_q;
    bus.vld = out_q.vld && (|out_q.rd);
  end

  assign oWbBus       = bus;
  assign oFwdBus      = bus;
  assign oConflictCnt = cnt_q;

endmodule
